aes256_round_engine: RTL and testbench

Iterative AES-256 encryption datapath that sits directly downstream of the key schedule. It drives the round index and key-enable lines into the key schedule, waits for each round key's ready pulse, and applies one AES round per accepted key. After accepting round key 14, it presents the 128-bit ciphertext. The block uses one clock, one state register and one S-box bank, and is shared across all 14 rounds.

---
 rtl/aes_pkg.sv | 54 +++++
 rtl/aes_sbox.sv | 13 +
 rtl/aes256_round_engine.sv | 167 ++++++++++++++++
 tb/tb_aes256_round_engine.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES-256 definitions: FSM state encoding, S-box table, GF(2^8) helpers.
// Optional key-timeout feature: AES_KEY_TIMEOUT_EN adds the ST_ERR state.
package aes_pkg;

   localparam int unsigned AES256_NR = 14;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KEYREQ,
      ST_ROUND,
      ST_DONE
`ifdef AES_KEY_TIMEOUT_EN
      ,ST_ERR
`endif
   } aes_state_e;

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   // Multiply by x in GF(2^8), reducing by x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // One MixColumns column; [31:24] is row 0.
   function automatic logic [31:0] mix_column(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// SubBytes: 16 parallel S-box lookups over the 128-bit state, purely combinational.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [127:0] i_data,
   output logic [127:0] o_data
);

   for (genvar g = 0; g < 16; g++) begin : g_byte
      assign o_data[8*g +: 8] = SBOX[i_data[8*g +: 8]];
   end

endmodule

// File: rtl/aes256_round_engine.sv
// Iterative AES-256 encryption engine driving an external key schedule.
// One round per accepted round key; one shared S-box bank.
// Optional feature: define AES_KEY_TIMEOUT_EN for the key-wait watchdog and ERR state.
module aes256_round_engine
   import aes_pkg::*;
#(
   parameter int unsigned NR = AES256_NR
`ifdef AES_KEY_TIMEOUT_EN
   ,parameter int unsigned KEY_TIMEOUT = 64
`endif
)(
   input  logic         clk_i,
   input  logic         rst_n,
   input  logic         start_i,
   input  logic [127:0] data_i,
   output logic         ready_o,
   output logic         busy_o,
   output logic         done_o,
   output logic [127:0] data_o,
   output logic [3:0]   round_o,
   output logic         key_en_o,
   input  logic         key_ready_i,
   input  logic [127:0] round_key_i,
   output logic         err_o
);

   localparam logic [3:0] LAST_ROUND = 4'(NR);

   aes_state_e   r_state, w_state_nxt;
   logic [127:0] r_data, r_data_o;
   logic [127:0] w_sub, w_shift, w_mix, w_round;
   logic [3:0]   r_round;
   logic         r_done, r_key_en;
   logic         w_accept, w_last;

   assign w_last = (r_round == LAST_ROUND);

`ifdef AES_KEY_TIMEOUT_EN
   localparam int unsigned TW = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(KEY_TIMEOUT - 1);
   logic [TW-1:0] r_tmo;
   logic          r_err;
   assign w_accept = start_i && ((r_state == ST_IDLE) || (r_state == ST_ERR));
`else
   assign w_accept = start_i && (r_state == ST_IDLE);
`endif

   aes_sbox u_sbox (
      .i_data (r_data),
      .o_data (w_sub)
   );

   // ShiftRows then MixColumns on the substituted state (byte 4c+r = row r, column c).
   always_comb begin
      w_shift = '0;
      w_mix   = '0;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned r = 0; r < 4; r++) begin
            w_shift[127 - 8*(4*c + r) -: 8] = w_sub[127 - 8*(4*((c + r) % 4) + r) -: 8];
         end
      end
      for (int unsigned c = 0; c < 4; c++) begin
         w_mix[127 - 32*c -: 32] = mix_column(w_shift[127 - 32*c -: 32]);
      end
   end

   // Select the round transform for the current round index and add the round key.
   always_comb begin
      if (r_round == 4'd0) begin
         w_round = r_data ^ round_key_i;
      end else if (w_last) begin
         w_round = w_shift ^ round_key_i;
      end else begin
         w_round = w_mix ^ round_key_i;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start_i) w_state_nxt = ST_KEYREQ;
         ST_KEYREQ: begin
            if (key_ready_i) begin
               w_state_nxt = ST_ROUND;
            end
`ifdef AES_KEY_TIMEOUT_EN
            else if (r_tmo == TMO_LAST) begin
               w_state_nxt = ST_ERR;
            end
`endif
         end
         ST_ROUND:  w_state_nxt = w_last ? ST_DONE : ST_KEYREQ;
         ST_DONE:   w_state_nxt = ST_IDLE;
`ifdef AES_KEY_TIMEOUT_EN
         ST_ERR:    if (start_i) w_state_nxt = ST_KEYREQ;
`endif
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath state, round index and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_data   <= '0;
         r_data_o <= '0;
         r_round  <= '0;
         r_done   <= 1'b0;
         r_key_en <= 1'b0;
      end else begin
         r_done   <= (r_state == ST_DONE);
         r_key_en <= (w_state_nxt == ST_KEYREQ);
         if (w_accept) begin
            r_data  <= data_i;
            r_round <= '0;
         end else if ((r_state == ST_KEYREQ) && key_ready_i) begin
            r_data <= w_round;
         end else if ((r_state == ST_ROUND) && !w_last) begin
            r_round <= r_round + 4'd1;
         end
         if (r_state == ST_DONE) begin
            r_data_o <= r_data;
         end
      end
   end

`ifdef AES_KEY_TIMEOUT_EN
   // Key-wait watchdog: counts KEYREQ cycles, sticky error until the next start.
   always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
         r_tmo <= '0;
         r_err <= 1'b0;
      end else begin
         if (r_state != ST_KEYREQ) begin
            r_tmo <= '0;
         end else if (!key_ready_i) begin
            r_tmo <= r_tmo + TW'(1);
         end
         if (w_accept) begin
            r_err <= 1'b0;
         end else if ((r_state == ST_KEYREQ) && (w_state_nxt == ST_ERR)) begin
            r_err <= 1'b1;
         end
      end
   end
   assign err_o = r_err;
`else
   assign err_o = 1'b0;
`endif

   assign ready_o  = (r_state == ST_IDLE);
   assign busy_o   = (r_state != ST_IDLE);
   assign done_o   = r_done;
   assign data_o   = r_data_o;
   assign round_o  = r_round;
   assign key_en_o = r_key_en;

endmodule

// File: tb/tb_aes256_round_engine.sv
// Directed bench for aes256_round_engine using the FIPS-197 C.3 AES-256 vector.
// Define AES_KEY_TIMEOUT_EN to also exercise the key-wait watchdog.
module tb_aes256_round_engine;

   logic         clk_i = 1'b0;
   logic         rst_n;
   logic         start_i;
   logic [127:0] data_i;
   logic         ready_o, busy_o, done_o, key_en_o, err_o, key_ready_i;
   logic [127:0] data_o, round_key_i;
   logic [3:0]   round_o;

   localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT = 128'h8ea2b7ca516745bfeafc49904b496089;

   logic [127:0] RK [0:14] = '{
      128'h000102030405060708090a0b0c0d0e0f,
      128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c,
      128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567,
      128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b,
      128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f,
      128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
      128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a,
      128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36
   };

   int n_checks = 0;
   int n_fail   = 0;

   // Key-model controls, written by the main sequence.
   int dly_max = 0;
   bit key_on  = 1'b1;
   bit spur    = 1'b0;
   bit fresh   = 1'b1;

   aes256_round_engine #(
`ifdef AES_KEY_TIMEOUT_EN
      .NR          (14),
      .KEY_TIMEOUT (8)
`else
      .NR          (14)
`endif
   ) dut (
      .clk_i       (clk_i),
      .rst_n       (rst_n),
      .start_i     (start_i),
      .data_i      (data_i),
      .ready_o     (ready_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .data_o      (data_o),
      .round_o     (round_o),
      .key_en_o    (key_en_o),
      .key_ready_i (key_ready_i),
      .round_key_i (round_key_i),
      .err_o       (err_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Key schedule model: answers each KEYREQ after a chosen delay, checks round_o sequencing.
   initial begin
      bit          pending = 1'b0;
      int          wait_cnt = 0;
      int          dly = 0;
      logic [3:0]  req_round = '0;
      logic [3:0]  last_r = '0;
      logic [3:0]  exp_r;
      key_ready_i = 1'b0;
      round_key_i = '0;
      forever begin
         @(negedge clk_i);
         key_ready_i = 1'b0;
         round_key_i = '0;
         if (rst_n !== 1'b1) begin
            pending = 1'b0;
            continue;
         end
         if (key_en_o) begin
            if (!pending) begin
               pending   = 1'b1;
               wait_cnt  = 0;
               dly       = int'($urandom_range(0, dly_max));
               req_round = round_o;
               exp_r     = fresh ? 4'd0 : last_r + 4'd1;
               check_eq("round_seq", {124'd0, round_o}, {124'd0, exp_r});
               fresh  = 1'b0;
               last_r = round_o;
            end else begin
               check_eq("round_stable", {124'd0, round_o}, {124'd0, req_round});
            end
            if (key_on && (wait_cnt >= dly)) begin
               key_ready_i = 1'b1;
               round_key_i = RK[round_o];
            end
            wait_cnt++;
         end else begin
            pending = 1'b0;
            if (spur && busy_o) begin
               key_ready_i = 1'b1;
               round_key_i = {4{32'hdeadbeef}};
            end
         end
      end
   end

   // One encryption of PT; lat counts clock edges from the accept edge to done_o.
   task automatic run_enc(input bit pulse_start, output int lat);
      @(negedge clk_i);
      fresh   = 1'b1;
      data_i  = PT;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      lat = 0;
      while (1) begin
         @(posedge clk_i);
         #1;
         lat++;
         if (done_o || lat > 400) break;
         if (pulse_start) start_i = ((lat % 7) == 3);
      end
      start_i = 1'b0;
   endtask

   task automatic check_reset_vals(input string pfx);
      check_eq({pfx, "_ready"},  {127'd0, ready_o},  128'd1);
      check_eq({pfx, "_busy"},   {127'd0, busy_o},   128'd0);
      check_eq({pfx, "_done"},   {127'd0, done_o},   128'd0);
      check_eq({pfx, "_err"},    {127'd0, err_o},    128'd0);
      check_eq({pfx, "_key_en"}, {127'd0, key_en_o}, 128'd0);
      check_eq({pfx, "_round"},  {124'd0, round_o},  128'd0);
      check_eq({pfx, "_data"},   data_o,             128'd0);
   endtask

   initial begin
      int lat;
      int n;
      rst_n   = 1'b0;
      start_i = 1'b0;
      data_i  = '0;

      repeat (3) @(posedge clk_i);
      #1;
      check_reset_vals("rst");
      @(negedge clk_i);
      rst_n = 1'b1;

      // Basic vector, key ready in the first KEYREQ cycle.
      run_enc(1'b0, lat);
      check_eq("c3_data", data_o, CT);
      check_eq("c3_latency", 128'(lat), 128'd31);

      // Random key-wait delays.
      dly_max = 5;
      run_enc(1'b0, lat);
      check_eq("rand_data", data_o, CT);
      check_eq("rand_lat_bound", 128'((lat >= 31) && (lat <= 31 + 15*5)), 128'd1);
      dly_max = 0;

      // Spurious start_i while busy and key_ready_i in ROUND.
      spur = 1'b1;
      run_enc(1'b1, lat);
      spur = 1'b0;
      check_eq("spur_data", data_o, CT);
      check_eq("spur_latency", 128'(lat), 128'd31);

      // Reset asserted during round 7.
      @(negedge clk_i);
      fresh   = 1'b1;
      data_i  = PT;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      n = 0;
      while ((round_o != 4'd7) && (n < 200)) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check_eq("reach_round7", {124'd0, round_o}, 128'd7);
      rst_n = 1'b0;
      #1;
      check_reset_vals("midrst");
      @(negedge clk_i);
      rst_n = 1'b1;
      run_enc(1'b0, lat);
      check_eq("postrst_data", data_o, CT);
      check_eq("postrst_latency", 128'(lat), 128'd31);

      // Back-to-back with start_i held high across done_o.
      @(negedge clk_i);
      fresh   = 1'b1;
      data_i  = PT;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      lat = 0;
      while (1) begin
         @(posedge clk_i);
         #1;
         lat++;
         if (done_o || lat > 400) break;
      end
      check_eq("b2b_first_latency", 128'(lat), 128'd31);
      check_eq("b2b_first_data", data_o, CT);
      fresh = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      check_eq("b2b_restart_busy", {127'd0, busy_o}, 128'd1);
      check_eq("b2b_restart_key_en", {127'd0, key_en_o}, 128'd1);
      check_eq("b2b_restart_round", {124'd0, round_o}, 128'd0);
      check_eq("b2b_hold_data", data_o, CT);
      lat = 0;
      while (1) begin
         @(posedge clk_i);
         #1;
         lat++;
         if (lat == 15) check_eq("b2b_mid_hold_data", data_o, CT);
         if (done_o || lat > 400) break;
      end
      check_eq("b2b_second_latency", 128'(lat), 128'd31);
      check_eq("b2b_second_data", data_o, CT);

`ifdef AES_KEY_TIMEOUT_EN
      // Watchdog: no key answer for 8 KEYREQ cycles.
      key_on = 1'b0;
      @(negedge clk_i);
      fresh   = 1'b1;
      data_i  = PT;
      start_i = 1'b1;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      n = 0;
      while (!err_o && (n < 100)) begin
         @(posedge clk_i);
         #1;
         n++;
      end
      check_eq("tmo_cycles", 128'(n), 128'd8);
      check_eq("tmo_err", {127'd0, err_o}, 128'd1);
      check_eq("tmo_key_en", {127'd0, key_en_o}, 128'd0);
      key_on = 1'b1;
      run_enc(1'b0, lat);
      check_eq("tmo_clear_err", {127'd0, err_o}, 128'd0);
      check_eq("tmo_restart_data", data_o, CT);
      check_eq("tmo_restart_latency", 128'(lat), 128'd31);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
